// File: rtl/segre_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : segre_store_buffer
// Purpose  : MEM-stage store FIFO that drains in program order into the data
//            cache write port and forwards buffered data to younger loads.
//            Optional store coalescing is enabled by defining SB_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module segre_store_buffer #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [BE_W-1:0]   push_be_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [BE_W-1:0]   ld_be_i,
    output logic              ld_fwd_hit_o,
    output logic [DATA_W-1:0] ld_fwd_data_o,
    input  logic              flush_i,
    input  logic              dc_busy_i,
    output logic              dc_wr_req_o,
    output logic [ADDR_W-1:0] dc_wr_addr_o,
    output logic [DATA_W-1:0] dc_wr_data_o,
    output logic [BE_W-1:0]   dc_wr_be_o,
    input  logic              dc_wr_ack_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              draining_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [BE_W-1:0]   be_q   [DEPTH];

    state_e            state_q;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              w_empty, w_full, w_draining;
    logic              w_req, w_ack, w_push_ok, w_merge, w_alloc, w_trigger;
    logic              w_fwd_match, w_ld_hit;
    logic [DATA_W-1:0] w_fwd_data;
    logic [BE_W-1:0]   w_fwd_be;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == CNT_W'(DEPTH));
    assign w_draining = (state_q == ST_DRAIN);

    assign w_req      = !w_empty && (w_draining || !dc_busy_i);
    assign w_ack      = dc_wr_ack_i && w_req;
    assign w_push_ok  = push_i && !w_draining;

    // Walk entries oldest to youngest so the youngest word match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_fwd_match = 1'b0;
        w_fwd_data  = '0;
        w_fwd_be    = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) &&
                (((addr_q[idx] ^ ld_addr_i) & WORD_MASK) == '0)) begin
                w_fwd_match = 1'b1;
                w_fwd_data  = data_q[idx];
                w_fwd_be    = be_q[idx];
            end
        end
    end

    assign w_ld_hit = ld_valid_i && w_fwd_match && ((w_fwd_be & ld_be_i) == ld_be_i);

`ifdef SB_COALESCE_EN
    logic [PTR_W-1:0] w_young_idx;
    assign w_young_idx = tail_q - PTR_W'(1);
    // A head entry already offered to the cache must not change under it.
    assign w_merge = w_push_ok && !w_empty &&
                     (((addr_q[w_young_idx] ^ push_addr_i) & WORD_MASK) == '0) &&
                     !((count_q == CNT_W'(1)) && w_req);
`else
    assign w_merge = 1'b0;
`endif

    assign w_alloc   = w_push_ok && !w_merge && (!w_full || w_ack);
    assign w_trigger = (push_i && w_full && !w_ack && !w_merge) ||
                       (ld_valid_i && w_fwd_match && !w_ld_hit) ||
                       (flush_i && !w_empty);

    always_comb begin
        head_d  = head_q + PTR_W'(w_ack);
        tail_d  = tail_q + PTR_W'(w_alloc);
        count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_ack);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            case (state_q)
                ST_IDLE:  if (w_trigger) state_q <= ST_DRAIN;
                ST_DRAIN: if (w_empty)   state_q <= ST_IDLE;
                default:                 state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_alloc) begin
            addr_q[tail_q] <= push_addr_i;
            data_q[tail_q] <= push_data_i;
            be_q[tail_q]   <= push_be_i;
        end
`ifdef SB_COALESCE_EN
        if (w_merge) begin
            for (int b = 0; b < BE_W; b++) begin
                if (push_be_i[b]) begin
                    data_q[w_young_idx][8*b +: 8] <= push_data_i[8*b +: 8];
                end
            end
            be_q[w_young_idx] <= be_q[w_young_idx] | push_be_i;
        end
`endif
    end

    assign ld_fwd_hit_o  = w_ld_hit;
    assign ld_fwd_data_o = w_fwd_data;
    assign dc_wr_req_o   = w_req;
    assign dc_wr_addr_o  = w_empty ? '0 : addr_q[head_q];
    assign dc_wr_data_o  = w_empty ? '0 : data_q[head_q];
    assign dc_wr_be_o    = w_empty ? '0 : be_q[head_q];
    assign full_o        = w_full;
    assign empty_o       = w_empty;
    assign draining_o    = w_draining;

`ifndef SYNTHESIS
    a_no_push_while_draining: assert property (
        @(posedge clk_i) disable iff (rst_i) !(push_i && w_draining));
`endif

endmodule
`default_nettype wire
